// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit-rate divisor.
package uart_pkg;

  localparam int UART_DEFAULT_DIVISOR = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side word interface of the UART receiver: held byte, status flags and the acknowledge level.
interface uart_rx_if;
  import uart_pkg::*;

  logic [7:0] arx_data;
  logic       arx_ready;
  logic       arx_overrun;
  logic       arx_frame_err;
  logic       arx_ack;

  // The CPU drives the acknowledge and reads everything else.
  modport master (
    output arx_ack,
    input  arx_data,
    input  arx_ready,
    input  arx_overrun,
    input  arx_frame_err
  );

  modport slave (
    input  arx_ack,
    output arx_data,
    output arx_ready,
    output arx_overrun,
    output arx_frame_err
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset value.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, one-byte holding register
// with sticky overrun/framing flags cleared by a rising edge of the CPU acknowledge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVISOR = UART_DEFAULT_DIVISOR
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rxd,
  uart_rx_if.slave cpu
);

  localparam int DW = $clog2(DIVISOR);
  localparam logic [DW-1:0] HALF_LOAD = DW'(DIVISOR / 2 - 1);
  localparam logic [DW-1:0] FULL_LOAD = DW'(DIVISOR - 1);

  if (DIVISOR < 4) begin : g_divisor_check
    $error("uart_rx: DIVISOR must be at least 4");
  end

  rx_state_t    state;
  logic [DW-1:0] div;
  logic [2:0]   bit_idx;
  logic [7:0]   shreg;
  logic [7:0]   data;
  logic         ready;
  logic         overrun;
  logic         frame_err;

  logic rx_s;
  logic ack_q;
  logic ack_qq;
  logic ack_rise;

  sync2 #(.RESET_VALUE(1'b1)) u_rxd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  sync2 #(.RESET_VALUE(1'b0)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cpu.arx_ack),
    .q     (ack_q)
  );

  always_ff @(posedge clk) begin
    if (reset) ack_qq <= 1'b0;
    else       ack_qq <= ack_q;
  end

  assign ack_rise = ack_q & ~ack_qq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: the acknowledge clear is written first; a frame event later in this block overrides it.
      if (ack_rise) begin
        ready     <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            div   <= HALF_LOAD;
            state <= START;
          end
        end

        START: begin
          if (div == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              div     <= FULL_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            div <= div - 1'b1;
          end
        end

        DATA: begin
          if (div == '0) begin
            shreg   <= {rx_s, shreg[7:1]};
            div     <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            div <= div - 1'b1;
          end
        end

        STOP: begin
          if (div == '0) begin
            if (rx_s) begin
              state <= IDLE;
              // A byte still held after this cycle's acknowledge is kept; the new one is dropped.
              if (ready && !ack_rise) begin
                overrun <= 1'b1;
              end else begin
                data  <= shreg;
                ready <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            div <= div - 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.arx_data      = data;
  assign cpu.arx_ready     = ready;
  assign cpu.arx_overrun   = overrun;
  assign cpu.arx_frame_err = frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIVISOR = 8: expected bytes queue in a scoreboard at send
// time and are popped when the receiver presents a new byte; flags are checked inline per scenario.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DIV    = 8;
  localparam int CLK_T  = 100;
  localparam int BIT_T  = DIV * CLK_T;

  logic clk;
  logic reset;
  logic rxd;

  uart_rx_if cpu ();

  uart_rx #(.DIVISOR(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .cpu   (cpu)
  );

  initial clk = 1'b0;
  always #(CLK_T / 2) clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb[$];

  // Scoreboard monitor: a new byte shows as ready rising or the held byte changing while ready.
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!reset && cpu.arx_ready && (!prev_ready || cpu.arx_data != prev_data)) begin
      total = total + 1;
      if (sb.size() == 0) begin
        $display("FAIL byte_out: got unexpected byte %02h, required none", cpu.arx_data);
      end else begin
        exp_byte = sb.pop_front();
        if (cpu.arx_data !== exp_byte)
          $display("FAIL byte_out: got %02h, required %02h", cpu.arx_data, exp_byte);
        else
          passed = passed + 1;
      end
    end
    prev_ready <= cpu.arx_ready;
    prev_data  <= cpu.arx_data;
  end

  initial begin
    #(CLK_T * 20000);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Drives start, 8 data bits LSB first, then the stop level, which is left on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_t,
                            input bit push);
    if (push) sb.push_back(b);
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_t);
    end
    rxd = stop_bit;
    #(bit_t);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    cpu.arx_ack = 1'b1;
    repeat (4) @(negedge clk);
    cpu.arx_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_flags(input string name, input logic [7:0] d, input logic rdy,
                             input logic ovr, input logic fe);
    total = total + 1;
    if (cpu.arx_data !== d || cpu.arx_ready !== rdy || cpu.arx_overrun !== ovr ||
        cpu.arx_frame_err !== fe)
      $display("FAIL %s: got data=%02h ready=%b overrun=%b frame_err=%b, required data=%02h ready=%b overrun=%b frame_err=%b",
               name, cpu.arx_data, cpu.arx_ready, cpu.arx_overrun, cpu.arx_frame_err,
               d, rdy, ovr, fe);
    else
      passed = passed + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd = 1'b1;
    cpu.arx_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_flags("reset_outputs", 8'h00, 1'b0, 1'b0, 1'b0);
    total = total + 1;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE);
    else passed = passed + 1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    @(negedge clk);
    fork
      send_frame(8'h55, 1'b1, BIT_T, 1'b1);
      begin
        @(posedge clk);
        repeat (77) @(posedge clk);
        #1;
        check_flags("single_before_t0_79", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_flags("single_at_t0_79", 8'h55, 1'b1, 1'b0, 1'b0);
      end
    join
    @(negedge clk);
    cpu.arx_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_flags("ack_two_clocks", 8'h55, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_flags("ack_three_clocks", 8'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cpu.arx_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_flags("glitch_no_byte", 8'h55, 1'b0, 1'b0, 1'b0);
    total = total + 1;
    if (dut.state !== IDLE) $display("FAIL glitch_state: got %0d, required %0d", dut.state, IDLE);
    else passed = passed + 1;
    @(negedge clk);
    send_frame(8'hA5, 1'b1, BIT_T, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_flags("after_glitch", 8'hA5, 1'b1, 1'b0, 1'b0);
    pulse_ack();
  endtask

  task automatic test_overrun();
    @(negedge clk);
    send_frame(8'h41, 1'b1, BIT_T, 1'b1);
    send_frame(8'h42, 1'b1, BIT_T, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_flags("overrun_set", 8'h41, 1'b1, 1'b1, 1'b0);
    pulse_ack();
    check_flags("overrun_cleared", 8'h41, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_error();
    @(negedge clk);
    send_frame(8'h00, 1'b0, BIT_T, 1'b0);
    repeat (40) @(negedge clk);
    check_flags("frame_err_break", 8'h41, 1'b0, 1'b0, 1'b1);
    total = total + 1;
    if (dut.state !== WAIT_HIGH)
      $display("FAIL break_state: got %0d, required %0d", dut.state, WAIT_HIGH);
    else passed = passed + 1;
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    send_frame(8'h0D, 1'b1, BIT_T, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_flags("after_break", 8'h0D, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    fork
      send_frame(8'h0A, 1'b1, BIT_T, 1'b1);
      begin
        @(posedge clk);
        repeat (75) @(posedge clk);
        #1;
        cpu.arx_ack = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check_flags("ack_with_stop", 8'h0A, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cpu.arx_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_and_rate();
    @(negedge clk);
    fork
      send_frame(8'hFF, 1'b1, BIT_T, 1'b0);
      begin
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_flags("mid_frame_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        total = total + 1;
        if (dut.state !== IDLE || dut.bit_idx !== 3'd0)
          $display("FAIL reset_fsm: got state=%0d bit_idx=%0d, required state=%0d bit_idx=0",
                   dut.state, dut.bit_idx, IDLE);
        else passed = passed + 1;
        @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check_flags("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    send_frame(8'h33, 1'b1, BIT_T * 97 / 100, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_flags("fast_rate", 8'h33, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    send_frame(8'h33, 1'b1, BIT_T * 103 / 100, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_flags("slow_rate", 8'h33, 1'b1, 1'b0, 1'b0);
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_overrun();
    test_frame_error();
    test_simultaneous();
    test_reset_and_rate();
    repeat (10) @(posedge clk);
    #1;
    total = total + 1;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d bytes pending, required 0", sb.size());
    else passed = passed + 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
